// File: rtl/half_pixel_loader.sv
// -----------------------------------------------------------------------------
// half_pixel_loader
//
// Front end of the half-precision inference datapath. Accepts a stream of 8-bit
// pixels, converts each one to binary16 (pixel/255, round-to-nearest-even),
// assembles LENGTH of them into a vector, pulses start, then holds the vector
// until the downstream layer reports done.
//
// Optional feature: define HALF_PIXEL_LOADER_LAST_CHECK_EN to check pixel_last
// framing and report violations on frame_error. When it is undefined,
// pixel_last is ignored and frame_error is tied low.
//
// Handshake: a pixel is transferred on a rising edge where pixel_valid and
// pixel_ready are both high. pixel_ready is a decode of the registered state
// and never depends on pixel_valid; pixel_data/pixel_last only matter while
// pixel_valid is high.
//
// Parameters:
//   LENGTH - pixels per frame / vector length (>= 2)
//   CNT_W  - pixel index counter width
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   pixel_valid in   pixel_data/pixel_last valid
//   pixel_ready out  loader can accept a pixel (FILL state)
//   pixel_data  in   unsigned pixel 0..255
//   pixel_last  in   final pixel of a frame (checked only with the macro)
//   start       out  one-cycle pulse, vector complete
//   vector      out  LENGTH binary16 values, index 0 = first pixel received
//   done        in   downstream finished with vector
//   frame_error out  one-cycle pulse on a framing violation
// -----------------------------------------------------------------------------
module half_pixel_loader #(
    parameter int LENGTH = 784,
    parameter int CNT_W  = $clog2(LENGTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pixel_valid,
    output logic                     pixel_ready,
    input  logic [7:0]               pixel_data,
    input  logic                     pixel_last,
    output logic                     start,
    output logic [LENGTH-1:0][15:0]  vector,
    input  logic                     done,
    output logic                     frame_error
);

    localparam logic [1:0] FILL  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LENGTH - 1);

    // RNE binary16 of k/255. For k > 0 the value lies in [1/255, 1], so it
    // is always normal: normalise by finding the shift s that brings k*2^s
    // into [255, 510), then divide with 10 extra fraction bits. 255 is odd,
    // so the remainder can never be exactly half and no tie handling is needed.
    function automatic logic [15:0] pix_to_half(input int k);
        int s;
        int num;
        int q;
        int r;
        logic [4:0] e;
        if (k == 0) begin
            return 16'h0000;
        end
        s = 0;
        while ((k << s) < 255) begin
            s = s + 1;
        end
        num = k << (s + 10);
        q   = num / 255;
        r   = num % 255;
        if (2 * r > 255) begin
            q = q + 1;
        end
        // Rounding up to 2.0 would move into the next binade.
        if (q >= 2048) begin
            q = q / 2;
            s = s - 1;
        end
        e = 5'(15 - s);
        return {1'b0, e, 10'(q)};
    endfunction

    function automatic logic [255:0][15:0] build_table();
        logic [255:0][15:0] t;
        for (int k = 0; k < 256; k++) begin
            t[k] = pix_to_half(k);
        end
        return t;
    endfunction

    localparam logic [255:0][15:0] HALF_TABLE = build_table();

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      conv;
    logic             accept;

    assign conv        = HALF_TABLE[pixel_data];
    assign pixel_ready = (state == FILL);
    assign start       = (state == START);
    assign accept      = pixel_valid && pixel_ready;

`ifndef HALF_PIXEL_LOADER_LAST_CHECK_EN
    logic unused_last;
    assign unused_last = pixel_last;
    assign frame_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FILL;
            cnt    <= '0;
            vector <= '0;
`ifdef HALF_PIXEL_LOADER_LAST_CHECK_EN
            frame_error <= 1'b0;
`endif
        end else begin
`ifdef HALF_PIXEL_LOADER_LAST_CHECK_EN
            frame_error <= 1'b0;
`endif
            case (state)
                FILL: begin
                    if (accept) begin
                        vector[cnt] <= conv;
`ifdef HALF_PIXEL_LOADER_LAST_CHECK_EN
                        // Only a pixel_last on the final index completes a
                        // frame; any mismatch discards the frame and restarts.
                        if (cnt == LAST_IDX) begin
                            cnt <= '0;
                            if (pixel_last) begin
                                state <= START;
                            end else begin
                                frame_error <= 1'b1;
                            end
                        end else if (pixel_last) begin
                            cnt         <= '0;
                            frame_error <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
`else
                        if (cnt == LAST_IDX) begin
                            cnt   <= '0;
                            state <= START;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
`endif
                    end
                end
                START: begin
                    state <= BUSY;
                end
                BUSY: begin
                    if (done) begin
                        state <= FILL;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_half_pixel_loader.sv
// -----------------------------------------------------------------------------
// tb_half_pixel_loader
//
// Directed bench for half_pixel_loader. A LENGTH=4 instance covers reset,
// the basic frame, BUSY hold, mid-frame reset and framing checks; a
// LENGTH=784 instance takes one full frame with random valid gaps.
// -----------------------------------------------------------------------------
module tb_half_pixel_loader;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // small instance (LENGTH = 4)
    logic             rst;
    logic             pixel_valid;
    logic             pixel_ready;
    logic [7:0]       pixel_data;
    logic             pixel_last;
    logic             start;
    logic [3:0][15:0] vec;
    logic             done;
    logic             frame_error;

    // large instance (LENGTH = 784)
    logic               b_rst;
    logic               b_valid;
    logic               b_ready;
    logic [7:0]         b_data;
    logic               b_last;
    logic               b_start;
    logic [783:0][15:0] b_vec;
    logic               b_done;
    logic               b_frame_error;

    half_pixel_loader #(.LENGTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .pixel_data  (pixel_data),
        .pixel_last  (pixel_last),
        .start       (start),
        .vector      (vec),
        .done        (done),
        .frame_error (frame_error)
    );

    half_pixel_loader #(.LENGTH(784)) dut_big (
        .clk         (clk),
        .rst         (b_rst),
        .pixel_valid (b_valid),
        .pixel_ready (b_ready),
        .pixel_data  (b_data),
        .pixel_last  (b_last),
        .start       (b_start),
        .vector      (b_vec),
        .done        (b_done),
        .frame_error (b_frame_error)
    );

    // ---------------- scoreboard ----------------
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent reference: k/255 in real arithmetic, normalised by doubling.
    function automatic logic [15:0] ref_half(input int k);
        real v;
        int  e;
        int  m;
        if (k == 0) begin
            return 16'h0000;
        end
        v = real'(k) / 255.0;
        e = 15;
        while (v < 1.0) begin
            v = v * 2.0;
            e--;
        end
        m = $rtoi(v * 1024.0 + 0.5);
        if (m >= 2048) begin
            m = m / 2;
            e++;
        end
        return {1'b0, e[4:0], m[9:0]};
    endfunction

    // ---------------- driver tasks ----------------
    // One pixel, accepted on the next edge (caller guarantees FILL).
    // Returns #1 after the accepting edge with valid dropped.
    task automatic push(input logic [7:0] d, input logic l);
        pixel_valid = 1'b1;
        pixel_data  = d;
        pixel_last  = l;
        @(posedge clk);
        #1;
        pixel_valid = 1'b0;
        pixel_last  = 1'b0;
    endtask

    // Called in the START cycle: step into BUSY, then present done for one edge.
    task automatic release_busy(input string tag);
        @(posedge clk);
        #1;
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        chk(tag, 64'(pixel_ready), 64'd1);
    endtask

    localparam logic [63:0] EXP_A  = 64'h3C00_3804_1C04_0000; // 0,1,128,255
    localparam logic [63:0] EXP_R  = 64'h0000_1C04_3804_2004; // 2,128,1,0
    localparam logic [63:0] EXP_B  = 64'h3804_3C00_0000_0000; // 0,0,255,128
`ifndef HALF_PIXEL_LOADER_LAST_CHECK_EN
    localparam logic [63:0] EXP_E  = 64'h2004_3804_1C04_3C00; // 255,1,128,2
`endif

    int i_acc;
    int starts;
    int cyc;
    logic acc;

    initial begin
        rst = 1'b1; pixel_valid = 1'b0; pixel_data = '0; pixel_last = 1'b0; done = 1'b0;
        b_rst = 1'b1; b_valid = 1'b0; b_data = '0; b_last = 1'b0; b_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // ---- reset state ----
        chk("reset_ready", 64'(pixel_ready), 64'd1);
        chk("reset_start", 64'(start), 64'd0);
        chk("reset_frame_error", 64'(frame_error), 64'd0);
        chk("reset_vector", vec, 64'd0);
        chk("big_reset_ready", 64'(b_ready), 64'd1);
        chk("big_reset_vector_zero", 64'(b_vec == '0), 64'd1);
        rst   = 1'b0;
        b_rst = 1'b0;

        // ---- basic frame 0,1,128,255 ----
        push(8'd0, 1'b0);
        chk("a0_start", 64'(start), 64'd0);
        push(8'd1, 1'b0);
        chk("a1_vector", vec, 64'h0000_0000_1C04_0000);
        push(8'd128, 1'b0);
        chk("a2_start", 64'(start), 64'd0);
        push(8'd255, 1'b1);
        chk("a3_start", 64'(start), 64'd1);
        chk("a3_ready", 64'(pixel_ready), 64'd0);
        chk("a3_vector", vec, EXP_A);

        // ---- hold valid through START/BUSY with changing data ----
        pixel_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            pixel_data = 8'($urandom_range(0, 255));
            pixel_last = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk($sformatf("busy%0d_start", k), 64'(start), 64'd0);
            chk($sformatf("busy%0d_ready", k), 64'(pixel_ready), 64'd0);
            chk($sformatf("busy%0d_vector", k), vec, EXP_A);
        end
        done = 1'b1;
        pixel_data = 8'($urandom_range(0, 255));
        @(posedge clk);
        #1;
        done = 1'b0;
        pixel_valid = 1'b0;
        pixel_last = 1'b0;
        chk("after_done_ready", 64'(pixel_ready), 64'd1);
        chk("after_done_vector", vec, EXP_A);
        chk("after_done_start", 64'(start), 64'd0);

        // ---- reset mid-frame ----
        push(8'd255, 1'b0);
        push(8'd255, 1'b0);
        chk("partial_vector", vec, 64'h3C00_3C00_3C00_3C00 & 64'h0000_0000_FFFF_FFFF | 64'h3C00_3804_0000_0000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midreset_vector", vec, 64'd0);
        chk("midreset_ready", 64'(pixel_ready), 64'd1);
        chk("midreset_start", 64'(start), 64'd0);
        push(8'd2, 1'b0);
        chk("r0_start", 64'(start), 64'd0);
        push(8'd128, 1'b0);
        chk("r1_start", 64'(start), 64'd0);
        push(8'd1, 1'b0);
        chk("r2_start", 64'(start), 64'd0);
        push(8'd0, 1'b1);
        chk("r3_start", 64'(start), 64'd1);
        chk("r3_vector", vec, EXP_R);
        release_busy("r_release_ready");

        // ---- pixel_last on pixel 2 of 4 ----
        push(8'd255, 1'b0);
        push(8'd1, 1'b1);
        chk("early_last_start", 64'(start), 64'd0);
`ifdef HALF_PIXEL_LOADER_LAST_CHECK_EN
        chk("early_last_frame_error", 64'(frame_error), 64'd1);
        chk("early_last_ready", 64'(pixel_ready), 64'd1);
        push(8'd0, 1'b0);
        chk("b0_frame_error", 64'(frame_error), 64'd0);
        push(8'd0, 1'b0);
        push(8'd255, 1'b0);
        chk("b2_start", 64'(start), 64'd0);
        push(8'd128, 1'b1);
        chk("b3_start", 64'(start), 64'd1);
        chk("b3_vector", vec, EXP_B);
        release_busy("b_release_ready");
        // missing last on the final pixel
        push(8'd1, 1'b0);
        push(8'd1, 1'b0);
        push(8'd1, 1'b0);
        push(8'd1, 1'b0);
        chk("no_last_frame_error", 64'(frame_error), 64'd1);
        chk("no_last_start", 64'(start), 64'd0);
        chk("no_last_ready", 64'(pixel_ready), 64'd1);
`else
        chk("early_last_frame_error", 64'(frame_error), 64'd0);
        push(8'd128, 1'b0);
        chk("e2_start", 64'(start), 64'd0);
        push(8'd2, 1'b1);
        chk("e3_start", 64'(start), 64'd1);
        chk("e3_frame_error", 64'(frame_error), 64'd0);
        chk("e3_vector", vec, EXP_E);
        release_busy("e_release_ready");
        push(8'd0, 1'b0);
        push(8'd0, 1'b0);
        push(8'd255, 1'b0);
        chk("b2_start", 64'(start), 64'd0);
        push(8'd128, 1'b0);
        chk("b3_start", 64'(start), 64'd1);
        chk("b3_vector", vec, EXP_B);
        chk("b3_frame_error", 64'(frame_error), 64'd0);
        release_busy("b_release_ready");
`endif

        // ---- full 784-pixel frame with random valid gaps ----
        i_acc  = 0;
        starts = 0;
        cyc    = 0;
        while (i_acc < 784 && cyc < 20000) begin
            b_valid = 1'($urandom_range(0, 1));
            b_data  = 8'(i_acc % 256);
            b_last  = (i_acc == 783);
            acc     = b_valid && b_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) i_acc++;
            if (b_start) starts++;
        end
        b_valid = 1'b0;
        b_last  = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (b_start) starts++;
        end
        chk("big_accepted", 64'(i_acc), 64'd784);
        chk("big_start_count", 64'(starts), 64'd1);
        chk("big_ready_busy", 64'(b_ready), 64'd0);
        chk("big_frame_error", 64'(b_frame_error), 64'd0);
        for (int j = 0; j < 784; j++) begin
            chk($sformatf("big_vec[%0d]", j), 64'(b_vec[j]), 64'(ref_half(j % 256)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/half_pixel_loader.md
# half_pixel_loader

Front end of the half-precision inference datapath. It accepts an MNIST-style stream of 8-bit pixels over a valid/ready handshake and converts each pixel to binary16 `pixel/255`. It assembles `LENGTH` pixels into the vector that feeds `half_dot_v_m`, pulses `start`, then holds the vector stable until the downstream layer reports `done`. In hardware it replaces the software image-load, scale and send sequence.

## Interface
- `LENGTH`, 784: pixels per frame, i.e. the vector length presented to the layer; must be ≥ 2.
- `CNT_W`, `$clog2(LENGTH)`: pixel index counter width.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pixel_valid`  in  1  `pixel_data`/`pixel_last` valid.
- `pixel_ready`  out  1  loader can accept a pixel.
- `pixel_data`  in  8  unsigned pixel, 0..255.
- `pixel_last`  in  1  marks the final pixel of a frame (see Configuration).
- `start`  out  1  one-cycle pulse: `vector` is complete.
- `vector`  out  `[LENGTH][16]`  binary16 pixels, index 0 = first pixel received.
- `done`  in  1  downstream layer finished with `vector`.
- `frame_error`  out  1  one-cycle pulse on a framing violation.

## Operation
- States: FILL, START, BUSY.
- **FILL**
  - `pixel_ready`=1.
  - On `pixel_valid && pixel_ready`, write the converted pixel to `vector[cnt]` and increment `cnt`.
  - On acceptance at `cnt == LENGTH-1`: `cnt` returns to 0 and the state goes to START.
- **START**
  - `start`=1 for exactly this cycle; `pixel_ready`=0.
  - Next state is BUSY unconditionally.
- **BUSY**
  - `pixel_ready`=0.
  - When `done`=1, go to FILL.
- `done` is ignored in FILL and START.
- `vector` changes only on accepted writes in FILL, so it is stable from START until `done` is seen.
- Conversion: `h = RNE_binary16(k/255)`, round-to-nearest-even, with k = `pixel_data`.
  - Realize as a 256-entry constant table generated by a function at elaboration time.
  - Result is always non-negative and normal, except 0.
  - 0→16'h0000, 1→16'h1C04, 2→16'h2004, 128→16'h3804, 255→16'h3C00.
- Conversion is combinational into the write port; there is no pipeline stage between accept and `vector` update.
- Reset (any state, including mid-frame or BUSY):
  - State goes to FILL and `cnt`=0.
  - `start`=0, `frame_error`=0, `pixel_ready`=1 on the first cycle after reset.
  - All `vector` entries become 16'h0000.
  - A partial frame is discarded; a frame in BUSY is abandoned.

## Timing
- `pixel_ready` is a registered state decode; it does not depend combinationally on `pixel_valid`.
- Throughput in FILL: one pixel per cycle.
- Last accepted pixel at edge N → `start`=1 during cycle N+1 → BUSY from N+2.
- `done` sampled high at edge M while in BUSY → `pixel_ready`=1 from M+1.
- Minimum frame period: `LENGTH` + 2 cycles + downstream latency.
- `vector[i]` reflects pixel i one cycle after the accepting edge.
- `frame_error` is asserted during the cycle after the offending accept edge.

## Configuration
- Macro: `HALF_PIXEL_LOADER_LAST_CHECK_EN`.
- **Defined**
  - `pixel_last`=1 accepted at `cnt != LENGTH-1`: pulse `frame_error`, reset `cnt` to 0, stay in FILL. The frame is discarded.
  - `pixel_last`=0 accepted at `cnt == LENGTH-1`: pulse `frame_error`, reset `cnt` to 0, stay in FILL. No `start` is issued.
  - Only `pixel_last`=1 at `cnt == LENGTH-1` completes a frame.
- **Undefined**
  - `pixel_last` is ignored and `frame_error` is tied 0.
  - A frame completes on every `LENGTH`-th accepted pixel.

## Test plan
- Reset, then LENGTH=4, stream 0,1,128,255 on consecutive cycles with last on the final pixel:
  - `start` pulses once, exactly 1 cycle after the final accept.
  - `vector` = {0000,1C04,3804,3C00}.
  - `pixel_ready`=0 until `done`.
- Hold `pixel_valid`=1 throughout START/BUSY with a changing `pixel_data`, assert `done` 10 cycles after `start`:
  - No pixel is accepted and `vector` is unchanged during BUSY.
  - `pixel_ready`=1 the cycle after `done`.
- Toggle `pixel_valid` randomly across a full LENGTH=784 frame of values i%256:
  - Each `vector[i]` matches the table value for i%256.
  - Exactly one `start` pulse.
- Assert `rst` after 2 of 4 pixels, then stream a complete frame:
  - Vector holds only the new frame.
  - The earlier partial frame never triggers `start`.
- With the macro defined, `pixel_last`=1 on pixel 2 of 4:
  - `frame_error` pulses, no `start`.
  - The following correct 4-pixel frame produces `start`.
- Without the macro, the same stimulus:
  - `frame_error` stays 0.
  - `start` fires after the 4th pixel.
